// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared types and helpers for the LED matrix scanner
package led_pkg;

    // Scan phase of the current column.
    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_LIT   = 1'b1
    } scan_state_t;

    // Number of lit PWM ticks per column for a given pixel depth.
    function automatic int lit_ticks(input int bpp);
        return (1 << bpp) - 1;
    endfunction

    // Converts a logical "on" into the electrical pin level.
    function automatic logic pin_level(input logic active, input logic act_low);
        return active ^ act_low;
    endfunction

endpackage

// File: rtl/led_scan_timer.sv
// rtl/led_scan_timer.sv - prescaler, BLANK/LIT scan FSM, PWM and column counters
//
// Ports:
//   clk12MHz, rst_n  clock, async active-low reset
//   tick             one-cycle strobe every PRESCALE clocks
//   lit              current column is in its lit phase
//   pwm_cnt          PWM step within the lit phase (0..2^BPP-2)
//   col_idx          column being scanned
//   frame_end        position is the last lit tick of the last column (qualify with tick)
//   frame_start      one-cycle pulse in the first cycle column 0 is lit
module led_scan_timer
    import led_pkg::*;
#(
    parameter int PRESCALE    = 1500,
    parameter int BLANK_TICKS = 1,
    parameter int BPP         = 3,
    parameter int COLS        = 4,
    parameter int COL_W       = 2
) (
    input  logic             clk12MHz,
    input  logic             rst_n,
    output logic             tick,
    output logic             lit,
    output logic [BPP-1:0]   pwm_cnt,
    output logic [COL_W-1:0] col_idx,
    output logic             frame_end,
    output logic             frame_start
);

    localparam int LIT_TICKS = lit_ticks(BPP);
    localparam int PW        = $clog2(PRESCALE);
    localparam int BW        = $clog2(BLANK_TICKS + 2);

    logic [PW-1:0]    presc_q;
    scan_state_t      state_q, state_d;
    logic [BW-1:0]    blank_q, blank_d;
    logic [BPP-1:0]   pwm_q, pwm_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             fs_q, fs_d;
    logic             last_blank, last_pwm, last_col;

    assign tick       = (presc_q == PW'(PRESCALE - 1));
    assign last_blank = (BLANK_TICKS == 0) || (blank_q == BW'(BLANK_TICKS - 1));
    assign last_pwm   = (pwm_q == BPP'(LIT_TICKS - 1));
    assign last_col   = (col_q == COL_W'(COLS - 1));

    assign lit         = (state_q == ST_LIT);
    assign pwm_cnt     = pwm_q;
    assign col_idx     = col_q;
    assign frame_end   = lit && last_pwm && last_col;
    assign frame_start = fs_q;

    always_ff @(posedge clk12MHz or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= tick ? '0 : presc_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        blank_d = blank_q;
        pwm_d   = pwm_q;
        col_d   = col_q;
        fs_d    = 1'b0;
        if (tick) begin
            if (state_q == ST_BLANK) begin
                if (last_blank) begin
                    state_d = ST_LIT;
                    blank_d = '0;
                    pwm_d   = '0;
                    fs_d    = (col_q == '0);
                end else begin
                    blank_d = blank_q + 1'b1;
                end
            end else begin
                if (last_pwm) begin
                    pwm_d = '0;
                    col_d = last_col ? '0 : col_q + 1'b1;
                    // Without blanking the next column is lit straight away.
                    if (BLANK_TICKS == 0) begin
                        fs_d = last_col;
                    end else begin
                        state_d = ST_BLANK;
                    end
                end else begin
                    pwm_d = pwm_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk12MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BLANK;
            blank_q <= '0;
            pwm_q   <= '0;
            col_q   <= '0;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            blank_q <= blank_d;
            pwm_q   <= pwm_d;
            col_q   <= col_d;
            fs_q    <= fs_d;
        end
    end

endmodule

// File: rtl/led_matrix_scanner.sv
// rtl/led_matrix_scanner.sv - double-buffered grayscale LED matrix column scanner
//
// Ports:
//   clk12MHz, rst_n  clock, async active-low reset
//   wr_en/wr_col/wr_data  write one column of the back buffer (row r = wr_data[r*BPP +: BPP])
//   swap_req         request front/back exchange at the next frame end
//   swap_pending     swap requested but not yet performed
//   swap_ack         one-cycle pulse when the swap takes effect
//   frame_start      one-cycle pulse when column 0 begins its lit phase
//   row, col         registered LED pins, polarity set by ROW_ACT_LOW / COL_ACT_LOW
module led_matrix_scanner
    import led_pkg::*;
#(
    parameter int ROWS        = 8,
    parameter int COLS        = 4,
    parameter int BPP         = 3,
    parameter int PRESCALE    = 1500,
    parameter int BLANK_TICKS = 1,
    parameter int ROW_ACT_LOW = 1,
    parameter int COL_ACT_LOW = 1
) (
    input  logic                    clk12MHz,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [$clog2(COLS)-1:0] wr_col,
    input  logic [ROWS*BPP-1:0]     wr_data,
    input  logic                    swap_req,
    output logic                    swap_pending,
    output logic                    swap_ack,
    output logic                    frame_start,
    output logic [ROWS-1:0]         row,
    output logic [COLS-1:0]         col
);

    localparam int   COL_W    = $clog2(COLS);
    localparam logic ROW_LOW  = (ROW_ACT_LOW != 0);
    localparam logic COL_LOW  = (COL_ACT_LOW != 0);

    logic             tick, lit, frame_end;
    logic [BPP-1:0]   pwm_cnt;
    logic [COL_W-1:0] col_idx;

    logic                sel_q, pending_q, ack_q;
    logic                swap_now, wr_ok;
    logic [ROWS*BPP-1:0] fb_q [2][COLS];
    logic [ROWS-1:0]     row_d, row_q;
    logic [COLS-1:0]     col_d, col_q;

    led_scan_timer #(
        .PRESCALE    (PRESCALE),
        .BLANK_TICKS (BLANK_TICKS),
        .BPP         (BPP),
        .COLS        (COLS),
        .COL_W       (COL_W)
    ) u_timer (
        .clk12MHz    (clk12MHz),
        .rst_n       (rst_n),
        .tick        (tick),
        .lit         (lit),
        .pwm_cnt     (pwm_cnt),
        .col_idx     (col_idx),
        .frame_end   (frame_end),
        .frame_start (frame_start)
    );

    assign swap_now = tick && frame_end && pending_q;
    // Non-power-of-two COLS leaves unused wr_col codes; those writes are dropped.
    assign wr_ok    = wr_en && ({1'b0, wr_col} < (COL_W + 1)'(COLS));

    // Writes target the bank that is back in this cycle, even in the swap cycle.
    always_ff @(posedge clk12MHz or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int c = 0; c < COLS; c++) begin
                    fb_q[b][c] <= '0;
                end
            end
        end else if (wr_ok) begin
            fb_q[~sel_q][wr_col] <= wr_data;
        end
    end

    // A request arriving in the swap cycle re-arms pending for the next frame.
    always_ff @(posedge clk12MHz or negedge rst_n) begin
        if (!rst_n) begin
            sel_q     <= 1'b0;
            pending_q <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            sel_q     <= sel_q ^ swap_now;
            ack_q     <= swap_now;
            pending_q <= swap_now ? swap_req : (pending_q | swap_req);
        end
    end

    assign swap_pending = pending_q;
    assign swap_ack     = ack_q;

    always_comb begin
        row_d = '0;
        col_d = '0;
        for (int r = 0; r < ROWS; r++) begin
            row_d[r] = pin_level(lit && (fb_q[sel_q][col_idx][r*BPP +: BPP] > pwm_cnt), ROW_LOW);
        end
        for (int c = 0; c < COLS; c++) begin
            col_d[c] = pin_level(lit && (col_idx == COL_W'(c)), COL_LOW);
        end
    end

    always_ff @(posedge clk12MHz or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= {ROWS{ROW_LOW}};
            col_q <= {COLS{COL_LOW}};
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row = row_q;
    assign col = col_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// tb/tb_led_matrix_scanner.sv - directed self-checking bench for led_matrix_scanner
module tb_led_matrix_scanner;

    logic clk12MHz = 1'b0;
    always #5 clk12MHz = ~clk12MHz;

    logic        rst_n;
    logic        wr_en_a, swap_req_a, swap_pending_a, swap_ack_a, frame_start_a;
    logic [1:0]  wr_col_a;
    logic [23:0] wr_data_a;
    logic [7:0]  row_a;
    logic [3:0]  col_a;

    logic        wr_en_b, swap_req_b, swap_pending_b, swap_ack_b, frame_start_b;
    logic [1:0]  wr_col_b;
    logic [23:0] wr_data_b;
    logic [7:0]  row_b;
    logic [2:0]  col_b;

    int checks = 0;
    int errors = 0;

    led_matrix_scanner #(
        .ROWS(8), .COLS(4), .BPP(3), .PRESCALE(4), .BLANK_TICKS(1),
        .ROW_ACT_LOW(1), .COL_ACT_LOW(1)
    ) dut_a (
        .clk12MHz(clk12MHz), .rst_n(rst_n), .wr_en(wr_en_a), .wr_col(wr_col_a),
        .wr_data(wr_data_a), .swap_req(swap_req_a), .swap_pending(swap_pending_a),
        .swap_ack(swap_ack_a), .frame_start(frame_start_a), .row(row_a), .col(col_a)
    );

    led_matrix_scanner #(
        .ROWS(8), .COLS(3), .BPP(3), .PRESCALE(2), .BLANK_TICKS(0),
        .ROW_ACT_LOW(0), .COL_ACT_LOW(0)
    ) dut_b (
        .clk12MHz(clk12MHz), .rst_n(rst_n), .wr_en(wr_en_b), .wr_col(wr_col_b),
        .wr_data(wr_data_b), .swap_req(swap_req_b), .swap_pending(swap_pending_b),
        .swap_ack(swap_ack_b), .frame_start(frame_start_b), .row(row_b), .col(col_b)
    );

    task automatic step();
        @(posedge clk12MHz);
        @(negedge clk12MHz);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int n, acks, pre_seen, pre_bad, post_seen, post_bad, other_bad, len;
    int multi, blanks, col1_on, bad, lit_seen;
    int lit_cnt [8];
    bit found;

    initial begin
        rst_n = 1'b0;
        wr_en_a = 1'b0; wr_col_a = '0; wr_data_a = '0; swap_req_a = 1'b0;
        wr_en_b = 1'b0; wr_col_b = '0; wr_data_b = '0; swap_req_b = 1'b0;
        repeat (3) step();

        check("rst_row_a", row_a, 8'hFF);
        check("rst_col_a", col_a, 4'hF);
        check("rst_pending", swap_pending_a, 1'b0);
        check("rst_ack", swap_ack_a, 1'b0);
        check("rst_frame_start", frame_start_a, 1'b0);
        check("rst_row_b", row_b, 8'h00);
        check("rst_col_b", col_b, 3'b000);

        rst_n = 1'b1;
        n = 0; found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(); n++;
            if (frame_start_a) found = 1;
        end
        check("first_lit_latency", n, 4);
        step();
        check("col0_pin", col_a, 4'hE);
        check("col0_rows_dark", row_a, 8'hFF);

        // Column 2 full brightness, swap requested twice inside one frame.
        wr_en_a = 1'b1; wr_col_a = 2'd2; wr_data_a = 24'hFFFFFF;
        step();
        wr_en_a = 1'b0;
        swap_req_a = 1'b1; step(); swap_req_a = 1'b0;
        check("pending_set", swap_pending_a, 1'b1);
        repeat (5) step();
        swap_req_a = 1'b1; step(); swap_req_a = 1'b0;
        check("pending_merged", swap_pending_a, 1'b1);

        acks = 0; pre_seen = 0; pre_bad = 0; post_seen = 0; post_bad = 0; other_bad = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (swap_ack_a) acks++;
            if (col_a == 4'hB) begin
                if (acks == 0) begin
                    pre_seen++;
                    if (row_a != 8'hFF) pre_bad++;
                end else begin
                    post_seen++;
                    if (row_a != 8'h00) post_bad++;
                end
            end else if (col_a != 4'hF && row_a != 8'hFF) begin
                other_bad++;
            end
        end
        check("single_ack", acks, 1);
        check("front_before_swap_seen", pre_seen, 28);
        check("front_before_swap_dark", pre_bad, 0);
        check("col2_lit_clocks", post_seen, 28);
        check("col2_rows_on", post_bad, 0);
        check("other_cols_dark", other_bad, 0);
        check("pending_cleared", swap_pending_a, 1'b0);

        // Level sweep: row r of column 0 at level r.
        wr_en_a = 1'b1; wr_col_a = 2'd0; wr_data_a = 24'hFAC688;
        step();
        wr_en_a = 1'b0;
        swap_req_a = 1'b1; step(); swap_req_a = 1'b0;
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            step();
            if (swap_ack_a) found = 1;
        end
        check("sweep_ack", found, 1'b1);
        for (int i = 0; i < 100 && col_a != 4'hE; i++) step();
        for (int r = 0; r < 8; r++) lit_cnt[r] = 0;
        len = 0;
        while (col_a == 4'hE && len < 60) begin
            for (int r = 0; r < 8; r++) if (!row_a[r]) lit_cnt[r]++;
            len++;
            step();
        end
        check("sweep_window", len, 28);
        for (int r = 0; r < 8; r++) begin
            check($sformatf("sweep_row%0d", r), lit_cnt[r], 4 * r);
        end

        // swap_req landing exactly in the swap cycle.
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            step();
            if (frame_start_a) found = 1;
        end
        check("frame_start_seen", found, 1'b1);
        swap_req_a = 1'b1; step(); swap_req_a = 1'b0;
        repeat (122) step();
        swap_req_a = 1'b1; step(); swap_req_a = 1'b0;
        check("swapcycle_ack", swap_ack_a, 1'b1);
        check("swapcycle_rearm", swap_pending_a, 1'b1);
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            step();
            if (swap_ack_a) found = 1;
        end
        check("second_frame_ack", found, 1'b1);
        check("second_frame_cleared", swap_pending_a, 1'b0);

        // Instance B: no blanking, active-high pins, out-of-range column write.
        wr_en_b = 1'b1; wr_col_b = 2'd1; wr_data_b = 24'hFFFFFF;
        step();
        wr_col_b = 2'd3;
        step();
        wr_en_b = 1'b0;
        swap_req_b = 1'b1; step(); swap_req_b = 1'b0;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            step();
            if (swap_ack_b) found = 1;
        end
        check("b_ack", found, 1'b1);
        multi = 0; blanks = 0; col1_on = 0; bad = 0;
        for (int i = 0; i < 84; i++) begin
            step();
            if ($countones(col_b) > 1) multi++;
            if (col_b == 3'b000) blanks++;
            if (col_b == 3'b010 && row_b == 8'hFF) col1_on++;
            if (col_b != 3'b010 && row_b != 8'h00) bad++;
        end
        check("b_one_col", multi, 0);
        check("b_no_blank", blanks, 0);
        check("b_col1_on", col1_on, 28);
        check("b_others_off", bad, 0);

        // Asynchronous reset while a column is lit.
        swap_req_a = 1'b1; step(); swap_req_a = 1'b0;
        for (int i = 0; i < 50 && col_a == 4'hF; i++) step();
        #2 rst_n = 1'b0;
        #1;
        check("async_row", row_a, 8'hFF);
        check("async_col", col_a, 4'hF);
        check("async_pending", swap_pending_a, 1'b0);
        @(negedge clk12MHz);
        step();
        rst_n = 1'b1;
        swap_req_a = 1'b1; step(); swap_req_a = 1'b0;
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            step();
            if (swap_ack_a) found = 1;
        end
        check("post_rst_ack", found, 1'b1);
        bad = 0; lit_seen = 0;
        for (int i = 0; i < 140; i++) begin
            step();
            if (row_a != 8'hFF) bad++;
            if (col_a != 4'hF) lit_seen++;
        end
        check("post_rst_buffers_zero", bad, 0);
        check("post_rst_scanning", lit_seen >= 112, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
